// File: rtl/i2c_master_byte_ctrl_if.sv
// i2c_master_byte_ctrl_if: host command/data and bit-controller signals of the byte controller
interface i2c_master_byte_ctrl_if;
   logic       start;
   logic       stop;
   logic       read;
   logic       write;
   logic       ack_in;
   logic [7:0] din;
   logic       cmd_ack;
   logic       ack_out;
   logic [7:0] dout;
   logic       i2c_al;
   logic [3:0] core_cmd;
   logic       core_txd;
   logic       core_ack;
   logic       core_rxd;
   logic       core_al;
   modport master (
      input  start, stop, read, write, ack_in, din, core_ack, core_rxd, core_al,
      output cmd_ack, ack_out, dout, i2c_al, core_cmd, core_txd
   );
   modport slave (
      output start, stop, read, write, ack_in, din, core_ack, core_rxd, core_al,
      input  cmd_ack, ack_out, dout, i2c_al, core_cmd, core_txd
   );
endinterface

// File: rtl/i2c_master_byte_ctrl.sv
// i2c_master_byte_ctrl: sequences START/byte/ACK/STOP bit commands for an I2C bit controller
module i2c_master_byte_ctrl (
   input logic                    clk,
   input logic                    rst,
   i2c_master_byte_ctrl_if.master bus
);
   localparam logic [3:0] CMD_NOP   = 4'b0000;
   localparam logic [3:0] CMD_START = 4'b0001;
   localparam logic [3:0] CMD_STOP  = 4'b0010;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b1000;
   typedef enum logic [2:0] {IDLE, START, WRITE, READ, ACK, STOP} state_t;
   state_t     state_q, state_d;
   logic [3:0] core_cmd_q, core_cmd_d;
   logic [7:0] sr_q, sr_d;
   logic [2:0] dcnt_q, dcnt_d;
   logic       core_txd_q, core_txd_d;
   logic       cmd_ack_q, cmd_ack_d;
   logic       ack_out_q, ack_out_d;
   logic       i2c_al_q, i2c_al_d;
   logic       ld, shift, go, cnt_done;
   assign go           = (bus.read | bus.write | bus.stop) & ~cmd_ack_q;
   assign cnt_done     = dcnt_q == 3'd0;
   assign bus.dout     = sr_q;
   assign bus.cmd_ack  = cmd_ack_q;
   assign bus.ack_out  = ack_out_q;
   assign bus.i2c_al   = i2c_al_q;
   assign bus.core_cmd = core_cmd_q;
   assign bus.core_txd = core_txd_q;
   // next state, bit command, data path update; arbitration loss overrides everything last
   always_comb begin
      state_d    = state_q;
      core_cmd_d = core_cmd_q;
      core_txd_d = core_txd_q;
      cmd_ack_d  = 1'b0;
      ack_out_d  = ack_out_q;
      i2c_al_d   = bus.core_al;
      ld         = 1'b0;
      shift      = 1'b0;
      case (state_q)
         IDLE: if (go) begin
            ld = 1'b1;
            if (bus.start) begin
               state_d    = START;
               core_cmd_d = CMD_START;
            end else if (bus.read) begin
               state_d    = READ;
               core_cmd_d = CMD_READ;
            end else if (bus.write) begin
               state_d    = WRITE;
               core_cmd_d = CMD_WRITE;
            end else begin
               state_d    = STOP;
               core_cmd_d = CMD_STOP;
            end
         end
         START: if (bus.core_ack) begin
            ld         = 1'b1;
            state_d    = bus.read ? READ : WRITE;
            core_cmd_d = bus.read ? CMD_READ : CMD_WRITE;
         end
         WRITE: if (bus.core_ack) begin
            shift      = 1'b1;
            state_d    = cnt_done ? ACK : WRITE;
            core_cmd_d = cnt_done ? CMD_READ : CMD_WRITE;
         end
         READ: if (bus.core_ack) begin
            shift      = 1'b1;
            state_d    = cnt_done ? ACK : READ;
            core_cmd_d = cnt_done ? CMD_WRITE : CMD_READ;
            core_txd_d = cnt_done ? bus.ack_in : core_txd_q;
         end
         ACK: if (bus.core_ack) begin
            ack_out_d  = bus.core_rxd;
            state_d    = bus.stop ? STOP : IDLE;
            core_cmd_d = bus.stop ? CMD_STOP : CMD_NOP;
            cmd_ack_d  = ~bus.stop;
         end
         STOP: if (bus.core_ack) begin
            state_d    = IDLE;
            core_cmd_d = CMD_NOP;
            cmd_ack_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      sr_d   = ld ? bus.din : shift ? {sr_q[6:0], bus.core_rxd} : sr_q;
      dcnt_d = ld ? 3'd7 : shift ? dcnt_q - 3'd1 : dcnt_q;
      if (state_d == WRITE) core_txd_d = sr_d[7];
      if (bus.core_al) begin
         state_d    = IDLE;
         core_cmd_d = CMD_NOP;
         core_txd_d = 1'b0;
         cmd_ack_d  = 1'b0;
      end
   end
   // state and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         core_cmd_q <= CMD_NOP;
         core_txd_q <= 1'b0;
         cmd_ack_q  <= 1'b0;
         ack_out_q  <= 1'b0;
         i2c_al_q   <= 1'b0;
         sr_q       <= 8'h00;
         dcnt_q     <= 3'd0;
      end else begin
         state_q    <= state_d;
         core_cmd_q <= core_cmd_d;
         core_txd_q <= core_txd_d;
         cmd_ack_q  <= cmd_ack_d;
         ack_out_q  <= ack_out_d;
         i2c_al_q   <= i2c_al_d;
         sr_q       <= sr_d;
         dcnt_q     <= dcnt_d;
      end
   end
endmodule
